// File: rtl/prog_loader_if.sv
// Byte-stream handshake between the host/debug source and the program loader.
// master: byte source (drives valid/data/last), slave: loader (drives ready).
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader for the 32x8 instruction/data memory.
// Streams bytes from the handshake interface into consecutive memory
// addresses starting at 0. It holds the CPU/memory in load mode (cpu_rst=0)
// until the stream ends, then releases them to run.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing
// two's-complement checksum byte after the in_last payload byte.
module prog_loader (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    prog_loader_if.slave     bus,
    output logic             cpu_rst,
    output logic             ewr,
    output logic [4:0]       ead,
    output logic [7:0]       edat,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
`ifdef LOADER_CHECKSUM_EN
        StChk   = 3'd2,
`endif
        StDrain = 3'd3,
        StRun   = 3'd4,
        StErr   = 3'd5
    } state_e;

    state_e     state_q;
    logic [4:0] addr_q;
    logic       cpu_rst_q;
    logic       ewr_q;
    logic [4:0] ead_q;
    logic [7:0] edat_q;
    logic       in_ready_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    // One settle cycle after the final accepted byte; the loader stops
    // accepting but stays busy before it drains or errors out.
    logic       fin_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
`endif

    logic xfer;
    assign xfer = bus.in_valid && in_ready_q;

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= 5'd0;
            cpu_rst_q  <= 1'b0;
            ewr_q      <= 1'b0;
            ead_q      <= 5'd0;
            edat_q     <= 8'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse; ead/edat hold.
            ewr_q <= 1'b0;
            case (state_q)
                StIdle, StRun, StErr: begin
                    if (start) begin
                        state_q    <= StLoad;
                        addr_q     <= 5'd0;
                        err_q      <= 1'b0;
                        cpu_rst_q  <= 1'b0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        fin_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= 8'd0;
`endif
                    end
                end

                StLoad: begin
                    if (fin_q) begin
                        fin_q   <= 1'b0;
                        state_q <= StDrain;
                    end else if (xfer) begin
                        ead_q  <= addr_q;
                        edat_q <= bus.in_data;
                        ewr_q  <= 1'b1;
                        addr_q <= addr_q + 5'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q  <= sum_q + bus.in_data;
`endif
                        if (bus.in_last) begin
`ifdef LOADER_CHECKSUM_EN
                            // Keep in_ready high to take the checksum byte.
                            state_q <= StChk;
`else
                            in_ready_q <= 1'b0;
                            fin_q      <= 1'b1;
`endif
                        end else if (addr_q == 5'd31) begin
                            // A 33rd byte would follow: byte 31 is written,
                            // then the load is aborted.
                            state_q    <= StErr;
                            err_q      <= 1'b1;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                StChk: begin
                    if (fin_q) begin
                        fin_q <= 1'b0;
                        // Payload plus checksum byte must wrap to zero.
                        if (sum_q == 8'd0) begin
                            state_q <= StDrain;
                        end else begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else if (xfer) begin
                        // Checksum byte is consumed but never written.
                        sum_q      <= sum_q + bus.in_data;
                        in_ready_q <= 1'b0;
                        fin_q      <= 1'b1;
                    end
                end
`endif

                StDrain: begin
                    state_q    <= StRun;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    cpu_rst_q  <= 1'b1;
                    in_ready_q <= 1'b0;
                end

                default: begin
                    state_q    <= StIdle;
                    cpu_rst_q  <= 1'b0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    fin_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign cpu_rst      = cpu_rst_q;
    assign ewr          = ewr_q;
    assign ead          = ead_q;
    assign edat         = edat_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
